// File: rtl/m_axis_rc_adapt_x16.sv
// m_axis_rc_adapt_x16: turns 512-bit UltraScale+ RC beats into 3DW Cpl/CplD TLP beats for the
// LitePCIe completion path, through a 2-entry skid buffer (1-cycle latency, full throughput).
module m_axis_rc_adapt_x16 #(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                     user_clk,
   input  logic                     user_reset_n,
   input  logic [DATA_WIDTH-1:0]    m_axis_rc_tdata_a,
   input  logic [DATA_WIDTH/32-1:0] m_axis_rc_tkeep_a,
   input  logic                     m_axis_rc_tlast_a,
   output logic                     m_axis_rc_tready_a,
   input  logic [160:0]             m_axis_rc_tuser_a,
   input  logic                     m_axis_rc_tvalid_a,
   output logic [DATA_WIDTH-1:0]    m_axis_rc_tdata,
   output logic [KEEP_WIDTH-1:0]    m_axis_rc_tkeep,
   output logic                     m_axis_rc_tlast,
   input  logic                     m_axis_rc_tready,
   output logic [1:0]               m_axis_rc_tuser,
   output logic                     m_axis_rc_tvalid,
   output logic                     len_err
);
   localparam int NDW   = DATA_WIDTH / 32;
   localparam int ENT_W = DATA_WIDTH + KEEP_WIDTH + 3;

   typedef enum logic {ST_FIRST, ST_BODY} state_t;

   state_t           state_q, state_d;
   logic [6:0]       cnt_q, cnt_d, exp_q, exp_d;
   logic             ec_err_q, ec_err_d;
   logic             len_err_q, len_err_d;
   logic             tready_a_q, tready_a_d;
   logic [ENT_W-1:0] ent_q [2];
   logic [ENT_W-1:0] ent_d [2];
   logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]       occ_q, occ_d;

   logic [31:0]           hdr0, hdr1, hdr2;
   logic [DATA_WIDTH-1:0] xdata;
   logic [KEEP_WIDTH-1:0] xkeep;
   logic [1:0]            xuser;
   logic [6:0]            cnt_now, exp_now, exp_use;
   logic                  is_first, ec_use, len_bad, accept, pop;
   logic                  unused_tuser;

   assign unused_tuser = ^{m_axis_rc_tuser_a[160:97], m_axis_rc_tuser_a[95:0]};

   // LitePCIe expects header DWs big-endian within each DW.
   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   always_comb begin
      is_first = (state_q == ST_FIRST);
      exp_now  = 7'((m_axis_rc_tdata_a[42:32] + 11'd18) >> 4);

      hdr0        = '0;
      hdr0[31:29] = (m_axis_rc_tdata_a[42:32] != 11'd0) ? 3'b010 : 3'b000;
      hdr0[28:24] = m_axis_rc_tdata_a[29] ? 5'b01011 : 5'b01010;
      hdr0[22:20] = m_axis_rc_tdata_a[91:89];
      hdr0[14]    = m_axis_rc_tdata_a[46];
      hdr0[13:12] = m_axis_rc_tdata_a[93:92];
      hdr0[9:0]   = m_axis_rc_tdata_a[41:32];
      hdr1 = {m_axis_rc_tdata_a[87:72], m_axis_rc_tdata_a[45:43], 1'b0, m_axis_rc_tdata_a[27:16]};
      hdr2 = {m_axis_rc_tdata_a[63:48], m_axis_rc_tdata_a[71:64], 1'b0, m_axis_rc_tdata_a[6:0]};

      xdata = m_axis_rc_tdata_a;
      xkeep = '0;
      for (int i = 0; i < NDW; i++) xkeep[4*i +: 4] = {4{m_axis_rc_tkeep_a[i]}};
      if (is_first) begin
         xdata[95:0] = {bswap32(hdr2), bswap32(hdr1), bswap32(hdr0)};
         xkeep[11:0] = '1;
      end

      // Beat count includes the current beat; saturates instead of wrapping.
      cnt_now = is_first ? 7'd1 : ((cnt_q == 7'h7F) ? cnt_q : cnt_q + 7'd1);
      exp_use = is_first ? exp_now : exp_q;
      ec_use  = is_first ? (m_axis_rc_tdata_a[15:12] != 4'd0) : ec_err_q;
      len_bad = m_axis_rc_tlast_a ? (cnt_now != exp_use) : (cnt_now == 7'd65);
      xuser   = {ec_use, len_bad | m_axis_rc_tuser_a[96]};

      accept = m_axis_rc_tvalid_a & tready_a_q;
      pop    = (occ_q != 2'd0) & m_axis_rc_tready;

      state_d   = state_q;
      cnt_d     = cnt_q;
      exp_d     = exp_q;
      ec_err_d  = ec_err_q;
      len_err_d = len_err_q;
      ent_d     = ent_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;

      if (accept) begin
         state_d  = m_axis_rc_tlast_a ? ST_FIRST : ST_BODY;
         cnt_d    = cnt_now;
         exp_d    = exp_use;
         ec_err_d = ec_use;
         if (len_bad) len_err_d = 1'b1;
         ent_d[wr_ptr_q] = {xdata, xkeep, m_axis_rc_tlast_a, xuser};
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;

      occ_d      = occ_q + {1'b0, accept} - {1'b0, pop};
      tready_a_d = (occ_d != 2'd2);
   end

   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         state_q    <= ST_FIRST;
         cnt_q      <= '0;
         exp_q      <= '0;
         ec_err_q   <= 1'b0;
         len_err_q  <= 1'b0;
         tready_a_q <= 1'b0;
         ent_q[0]   <= '0;
         ent_q[1]   <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         occ_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         exp_q      <= exp_d;
         ec_err_q   <= ec_err_d;
         len_err_q  <= len_err_d;
         tready_a_q <= tready_a_d;
         ent_q      <= ent_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
      end
   end

   assign {m_axis_rc_tdata, m_axis_rc_tkeep, m_axis_rc_tlast, m_axis_rc_tuser} = ent_q[rd_ptr_q];
   assign m_axis_rc_tvalid   = (occ_q != 2'd0);
   assign m_axis_rc_tready_a = tready_a_q;
   assign len_err            = len_err_q;

endmodule

// File: tb/tb_m_axis_rc_adapt_x16.sv
// Scoreboard bench for m_axis_rc_adapt_x16: the driver queues expected TLP beats, a negedge
// monitor pops and compares each output handshake.
`timescale 1ns/1ps
module tb_m_axis_rc_adapt_x16;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [511:0] tdata_a;
   logic [15:0]  tkeep_a;
   logic         tlast_a;
   logic         tready_a;
   logic [160:0] tuser_a;
   logic         tvalid_a;
   logic [511:0] tdata;
   logic [63:0]  tkeep;
   logic         tlast;
   logic         tready = 1'b0;
   logic [1:0]   tuser;
   logic         tvalid;
   logic         len_err;

   always #5 clk = ~clk;

   m_axis_rc_adapt_x16 dut (
      .user_clk(clk), .user_reset_n(rst_n),
      .m_axis_rc_tdata_a(tdata_a), .m_axis_rc_tkeep_a(tkeep_a), .m_axis_rc_tlast_a(tlast_a),
      .m_axis_rc_tready_a(tready_a), .m_axis_rc_tuser_a(tuser_a), .m_axis_rc_tvalid_a(tvalid_a),
      .m_axis_rc_tdata(tdata), .m_axis_rc_tkeep(tkeep), .m_axis_rc_tlast(tlast),
      .m_axis_rc_tready(tready), .m_axis_rc_tuser(tuser), .m_axis_rc_tvalid(tvalid),
      .len_err(len_err)
   );

   typedef struct {
      logic [511:0] d;
      logic [63:0]  k;
      logic         l;
      logic [1:0]   u;
   } exp_t;

   exp_t sbq[$];
   int   acc_cyc[$];
   int   out_cyc[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   n_in = 0;
   int   n_out = 0;
   logic rnd_rdy = 1'b0;
   logic hold_rdy = 1'b1;

   task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_in  <= 0;
         n_out <= 0;
      end else begin
         if (tvalid_a && tready_a) n_in <= n_in + 1;
         if (tvalid && tready) n_out <= n_out + 1;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      tready = rnd_rdy ? 1'($urandom_range(0, 1)) : hold_rdy;
   end

   // Monitor
   initial forever begin
      @(negedge clk);
      if (rst_n && tvalid && tready) begin
         out_cyc.push_back(cyc);
         if (sbq.size() == 0) chk("unexpected_out_tvalid", tvalid, 0);
         else begin
            exp_t e;
            e = sbq.pop_front();
            chk("tdata", tdata, e.d);
            chk("tkeep", tkeep, e.k);
            chk("tlast", tlast, e.l);
            chk("tuser", tuser, e.u);
         end
      end
      if (rst_n && (n_in - n_out) == 2) chk("tready_a_when_full", tready_a, 0);
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [95:0] mk_desc(input logic [10:0] dwc, input logic [12:0] bc,
         input logic [11:0] la, input logic [3:0] ec, input logic lk, input logic [2:0] st,
         input logic ep, input logic [15:0] rid, input logic [7:0] tag, input logic [15:0] cid,
         input logic [2:0] tc, input logic [2:0] attr);
      logic [95:0] r;
      r = '0;
      r[11:0] = la;   r[15:12] = ec;  r[28:16] = bc;  r[29] = lk;
      r[42:32] = dwc; r[45:43] = st;  r[46] = ep;     r[63:48] = rid;
      r[71:64] = tag; r[87:72] = cid; r[91:89] = tc;  r[94:92] = attr;
      return r;
   endfunction

   // Expected 3DW Cpl header as it appears on the output bus (each DW byte-reversed).
   function automatic logic [95:0] model_hdr(input logic [95:0] r);
      logic [31:0] h [3];
      logic [95:0] o;
      h[0] = '0;
      h[0][31:29] = (r[42:32] == 0) ? 3'b000 : 3'b010;
      h[0][28:24] = r[29] ? 5'h0B : 5'h0A;
      h[0][22:20] = r[91:89];
      h[0][14]    = r[46];
      h[0][13:12] = r[93:92];
      h[0][9:0]   = r[41:32];
      h[1] = {r[87:72], r[45:43], 1'b0, r[27:16]};
      h[2] = {r[63:48], r[71:64], 1'b0, r[6:0]};
      for (int w = 0; w < 3; w++)
         for (int b = 0; b < 4; b++) o[32*w + 8*b +: 8] = h[w][31-8*b -: 8];
      return o;
   endfunction

   task automatic send_beat(input logic [511:0] d, input logic [15:0] k, input logic l,
                            input logic disc, output logic ok);
      int w;
      w = 0;
      tdata_a = d; tkeep_a = k; tlast_a = l;
      tuser_a = '0; tuser_a[96] = disc;
      tvalid_a = 1'b1;
      ok = 1'b0;
      while (!ok && w < 1000) begin
         @(negedge clk);
         ok = tready_a;
         @(posedge clk);
         #1;
         w++;
      end
      if (ok) acc_cyc.push_back(cyc);
      else begin
         total++; bad++;
         $display("FAIL accept_timeout: beat not taken in %0d cycles, want taken", w);
      end
      tvalid_a = 1'b0;
   endtask

   task automatic send_tlp(input logic [95:0] desc, input logic [95:0] hdr, input int nb,
                           input int disc_at, input logic [15:0] kfirst);
      int dwc, expb;
      dwc  = int'(desc[42:32]);
      expb = (dwc + 3) / 16 + ((((dwc + 3) % 16) != 0) ? 1 : 0);
      for (int i = 1; i <= nb; i++) begin
         logic [511:0] d;
         logic [15:0]  k;
         logic         lst, ok;
         exp_t         e;
         d = rnd512();
         if (i == 1) d[95:0] = desc;
         k = (i == 1) ? kfirst : ((i == nb) ? 16'h003F : 16'hFFFF);
         lst = (i == nb);
         e.d = d;
         if (i == 1) e.d[95:0] = hdr;
         for (int j = 0; j < 16; j++) e.k[4*j +: 4] = k[j] ? 4'hF : 4'h0;
         if (i == 1) e.k[11:0] = 12'hFFF;
         e.l = lst;
         e.u[0] = (i == disc_at) || (lst ? (i != expb) : (i == 65));
         e.u[1] = (desc[15:12] != 4'd0);
         send_beat(d, k, lst, (i == disc_at), ok);
         if (ok) sbq.push_back(e);
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sbq.size() != 0 && w < 5000) begin
         @(posedge clk);
         w++;
      end
      if (sbq.size() != 0) begin
         total++; bad++;
         $display("FAIL drain: %0d beats outstanding, want 0", sbq.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [95:0]  ds;
      logic         ok;
      logic [511:0] d;
      rst_n = 1'b0; tvalid_a = 1'b0; tdata_a = '0; tkeep_a = '0; tlast_a = 1'b0; tuser_a = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tready_a", tready_a, 0);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_tuser", tuser, 0);
      chk("rst_len_err", len_err, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("tready_a_after_rst", tready_a, 1);

      // Single-beat CplD, hand-computed header
      ds = mk_desc(11'd1, 13'd4, 12'd0, 4'd0, 1'b0, 3'd0, 1'b0, 16'h0, 8'h2A, 16'h0, 3'd0, 3'd0);
      send_tlp(ds, {32'h002A0000, 32'h04000000, 32'h0100004A}, 1, 0, 16'h000F);
      @(negedge clk);
      chk("lat1_tvalid", tvalid, 1);
      chk("lat1_tkeep", tkeep, 64'hFFFF);
      chk("lat1_dw0", tdata[31:0], 32'h0100004A);
      drain();

      // Three-beat CplD back-to-back
      ds = mk_desc(11'd32, 13'd128, 12'h040, 4'd0, 1'b0, 3'd0, 1'b0, 16'h0100, 8'h11, 16'h0200,
                   3'd2, 3'd1);
      acc_cyc.delete();
      out_cyc.delete();
      send_tlp(ds, model_hdr(ds), 3, 0, 16'hFFFF);
      drain();
      chk("b2b_in_cycles", acc_cyc[2] - acc_cyc[0], 2);
      chk("b2b_out_cycles", out_cyc[2] - out_cyc[0], 2);

      // Cpl with UR status and error code
      ds = mk_desc(11'd0, 13'd8, 12'h013, 4'h1, 1'b0, 3'b001, 1'b0, 16'hABCD, 8'h05, 16'h1234,
                   3'd0, 3'd0);
      send_tlp(ds, {32'h1305CDAB, 32'h08203412, 32'h0000000A}, 1, 0, 16'h0007);
      @(negedge clk);
      chk("ur_tuser", tuser, 2'b10);
      drain();
      chk("len_err_clean", len_err, 0);

      // Locked Cpl, max-length CplD (dwc=1024, bc=4096), discontinue on a body beat
      ds = mk_desc(11'd0, 13'd4, 12'h7F, 4'd0, 1'b1, 3'd0, 1'b1, 16'h1, 8'h2, 16'h3, 3'd7, 3'd3);
      send_tlp(ds, model_hdr(ds), 1, 0, 16'h0);
      ds = mk_desc(11'd1024, 13'h1000, 12'h0, 4'd0, 1'b0, 3'd0, 1'b0, 16'h5, 8'h6, 16'h7, 3'd1,
                   3'd0);
      send_tlp(ds, model_hdr(ds), 65, 0, 16'hFFFF);
      ds = mk_desc(11'd20, 13'd80, 12'h0, 4'd0, 1'b0, 3'd0, 1'b0, 16'h8, 8'h9, 16'hA, 3'd0, 3'd0);
      send_tlp(ds, model_hdr(ds), 2, 2, 16'hFFFF);
      drain();
      chk("len_err_still_clean", len_err, 0);

      // Short TLP: dwc=16 needs 2 beats but ends on the first
      ds = mk_desc(11'd16, 13'd64, 12'h0, 4'd0, 1'b0, 3'd0, 1'b0, 16'h1, 8'h3C, 16'h2, 3'd0, 3'd0);
      send_tlp(ds, model_hdr(ds), 1, 0, 16'hFFFF);
      drain();
      chk("len_err_set", len_err, 1);
      ds = mk_desc(11'd4, 13'd16, 12'h0, 4'd0, 1'b0, 3'd0, 1'b0, 16'h1, 8'h3D, 16'h2, 3'd0, 3'd0);
      send_tlp(ds, model_hdr(ds), 1, 0, 16'hFFFF);
      drain();
      chk("len_err_sticky", len_err, 1);

      // Random traffic with 50% downstream ready
      rnd_rdy = 1'b1;
      for (int t = 0; t < 1000; t++) begin
         logic [95:0] r;
         int nb, da;
         r = {$urandom, $urandom, $urandom};
         r[42:32] = 11'($urandom_range(0, 80));
         nb = (int'(r[42:32]) + 3 + 15) / 16;
         if ($urandom_range(0, 19) == 0) nb = nb + 1;
         da = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, nb)) : 0;
         send_tlp(r, model_hdr(r), nb, da, 16'($urandom));
      end
      rnd_rdy = 1'b0;
      drain();

      // Reset in the middle of a 3-beat TLP
      hold_rdy = 1'b0;
      @(posedge clk);
      #1;
      ds = mk_desc(11'd32, 13'd128, 12'h0, 4'd0, 1'b0, 3'd0, 1'b0, 16'h1, 8'h44, 16'h2, 3'd0, 3'd0);
      d = rnd512();
      d[95:0] = ds;
      send_beat(d, 16'hFFFF, 1'b0, 1'b0, ok);
      send_beat(rnd512(), 16'hFFFF, 1'b0, 1'b0, ok);
      @(negedge clk);
      chk("pre_rst_tvalid", tvalid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_tvalid", tvalid, 0);
      chk("midrst_tdata", tdata, 0);
      chk("midrst_tkeep", tkeep, 0);
      chk("midrst_tready_a", tready_a, 0);
      chk("midrst_len_err", len_err, 0);
      sbq.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      hold_rdy = 1'b1;
      ds = mk_desc(11'd1, 13'd4, 12'h21, 4'd0, 1'b0, 3'd0, 1'b0, 16'h9, 8'h77, 16'h4, 3'd0, 3'd0);
      send_tlp(ds, model_hdr(ds), 1, 0, 16'h0001);
      drain();
      chk("sb_empty", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
